// File: rtl/mm_tile_controller.sv
// ---------------------------------------------------------------------------
// mm_tile_controller
//
// Sequences an ARRAY_DIM x ARRAY_DIM systolic PE array over an MxK * KxN
// matrix multiply. It latches the job configuration at start, streams the
// A/B global-buffer reads tile by tile, drives PE clear/write-enable and
// bubble controls, and writes each finished output tile back to global
// buffer P one column word per cycle. Partial tiles are supported when M or
// N is not a multiple of ARRAY_DIM. A zero dimension rejects the job with
// err_o. abort_i cancels any job on the next cycle.
//
// Optional feature: define MM_TILE_CTRL_PERF_EN to add cycle_cnt_o, a
// saturating count of cycles spent in RUN for the most recent job.
//
// Ports
//   clk_i, rst_i            clock; asynchronous active-high reset
//   start_i                 level start, sampled in IDLE
//   abort_i                 synchronous abort, wins over everything else
//   valid_o, err_o          job finished / job rejected (err valid with valid)
//   m_i, k_i, n_i           matrix dimensions
//   base_addr{a,b,p}_i      global buffer base addresses
//   pe_clr_o, pe_we_o       PE accumulator clear / result capture
//   ensys_o, bubble_o       systolic setup enable / bubble insertion
//   ena_o, addra_o          GB A read stream
//   enb_o, addrb_o          GB B read stream
//   enp_o, wep_o, addrp_o   GB P write stream
//   wordp_sel_o             column word select for the P data mux
//   cycle_cnt_o             (MM_TILE_CTRL_PERF_EN only) RUN cycle count
// ---------------------------------------------------------------------------
module mm_tile_controller #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ARRAY_DIM  = 8,
  parameter int unsigned OUTPUT_LAT = 2,
  parameter int unsigned WORD_SHIFT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  output logic                          valid_o,
  output logic                          err_o,
  input  logic [ADDR_WIDTH-1:0]         m_i,
  input  logic [ADDR_WIDTH-1:0]         k_i,
  input  logic [ADDR_WIDTH-1:0]         n_i,
  input  logic [ADDR_WIDTH-1:0]         base_addra_i,
  input  logic [ADDR_WIDTH-1:0]         base_addrb_i,
  input  logic [ADDR_WIDTH-1:0]         base_addrp_i,
  output logic                          pe_clr_o,
  output logic                          pe_we_o,
  output logic                          ensys_o,
  output logic                          bubble_o,
  output logic                          ena_o,
  output logic [ADDR_WIDTH-1:0]         addra_o,
  output logic                          enb_o,
  output logic [ADDR_WIDTH-1:0]         addrb_o,
  output logic                          enp_o,
  output logic                          wep_o,
  output logic [ADDR_WIDTH-1:0]         addrp_o,
  output logic [$clog2(ARRAY_DIM)-1:0]  wordp_sel_o
`ifdef MM_TILE_CTRL_PERF_EN
  ,
  output logic [31:0]                   cycle_cnt_o
`endif
);

  localparam int unsigned SEL_W = $clog2(ARRAY_DIM);
  localparam int unsigned LEN_W = $clog2(ARRAY_DIM + 1);
  localparam int unsigned SR_D  = ARRAY_DIM + OUTPUT_LAT;

  localparam logic [ADDR_WIDTH-1:0] DIM_A = ADDR_WIDTH'(ARRAY_DIM);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
  localparam logic [LEN_W-1:0]      DIM_L = LEN_W'(ARRAY_DIM);

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} main_state_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} sub_state_e;

  main_state_e main_q, main_d;
  sub_state_e  rd_q, rd_d;
  sub_state_e  wr_q, wr_d;

  // Latched job configuration
  logic [ADDR_WIDTH-1:0] m_q, k_q, n_q;
  logic [ADDR_WIDTH-1:0] base_a_q, base_b_q, base_p_q;
  logic                  err_q;

  // Tile geometry derived from the latched dimensions
  logic [ADDR_WIDTH-1:0] rt, ct, tc, n_rem;
  logic [LEN_W-1:0]      last_w;

  // Read loop counters; the offsets track r*K and c*K without multipliers
  logic [ADDR_WIDTH-1:0] r_q, c_q, t_q;
  logic [ADDR_WIDTH-1:0] a_off_q, b_off_q;

  // Issue-aligned PE controls
  logic pe_clr_q, pe_we_q, bubble_q, ensys_q;

  // Write-back path
  logic [SR_D-1:0]       sr_q;
  logic                  launch;
  logic                  wr_active_q;
  logic [SEL_W-1:0]      sel_q;
  logic [LEN_W-1:0]      len_q;
  logic [ADDR_WIDTH-1:0] wc_q;
  logic [ADDR_WIDTH-1:0] wr_idx_q;

  logic job_go, run_go, dims_zero_in;
  logic rd_busy, rd_last, rd_en, burst_end;

  assign dims_zero_in = (m_i == '0) || (k_i == '0) || (n_i == '0);
  assign job_go       = (main_q == M_IDLE) && start_i && !abort_i;
  assign run_go       = job_go && !dims_zero_in;

  assign rt     = m_q / DIM_A + ADDR_WIDTH'(|(m_q % DIM_A));
  assign ct     = n_q / DIM_A + ADDR_WIDTH'(|(n_q % DIM_A));
  assign tc     = (k_q > DIM_A) ? k_q : DIM_A;
  assign n_rem  = n_q % DIM_A;
  assign last_w = (n_rem == '0) ? DIM_L : LEN_W'(n_rem);

  assign rd_busy = (rd_q == S_BUSY);
  assign rd_last = rd_busy && (t_q == tc - ONE_A) && (c_q == ct - ONE_A) &&
                   (r_q == rt - ONE_A);
  assign rd_en   = rd_busy && (t_q < k_q);

  assign launch    = sr_q[SR_D-1];
  assign burst_end = wr_active_q && (LEN_W'(sel_q) == len_q - LEN_W'(1));

  // -------------------------------------------------------------------------
  // Main FSM
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) main_q <= M_IDLE;
    else       main_q <= main_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    main_d = main_q;
    unique case (main_q)
      M_IDLE: if (job_go) main_d = dims_zero_in ? M_DONE : M_RUN;
      M_RUN:  if (rd_q == S_DONE && wr_q == S_DONE) main_d = M_DONE;
      M_DONE: if (!start_i) main_d = M_IDLE;
      default: main_d = M_IDLE;
    endcase
    if (abort_i) main_d = M_IDLE;
  end

  always_comb begin
    valid_o = (main_q == M_DONE);
    err_o   = (main_q == M_DONE) && err_q;
  end

  // Configuration is captured only on the accepting cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_p_q <= '0;
      err_q    <= 1'b0;
    end else if (abort_i) begin
      err_q <= 1'b0;
    end else if (job_go) begin
      m_q      <= m_i;
      k_q      <= k_i;
      n_q      <= n_i;
      base_a_q <= base_addra_i;
      base_b_q <= base_addrb_i;
      base_p_q <= base_addrp_i;
      err_q    <= dims_zero_in;
    end
  end

  // -------------------------------------------------------------------------
  // Read FSM: r (slow) / c / t (fast), one t per cycle
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_q <= S_IDLE;
    else       rd_q <= rd_d;
  end

  always_comb begin
    rd_d = rd_q;
    unique case (rd_q)
      S_IDLE: if (run_go) rd_d = S_BUSY;
      S_BUSY: if (rd_last) rd_d = S_DONE;
      S_DONE: if (main_q != M_RUN) rd_d = S_IDLE;
      default: rd_d = S_IDLE;
    endcase
    if (abort_i) rd_d = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q     <= '0;
      c_q     <= '0;
      t_q     <= '0;
      a_off_q <= '0;
      b_off_q <= '0;
    end else if (abort_i || !rd_busy || rd_last) begin
      r_q     <= '0;
      c_q     <= '0;
      t_q     <= '0;
      a_off_q <= '0;
      b_off_q <= '0;
    end else if (t_q == tc - ONE_A) begin
      t_q <= '0;
      if (c_q == ct - ONE_A) begin
        c_q     <= '0;
        b_off_q <= '0;
        r_q     <= r_q + ONE_A;
        a_off_q <= a_off_q + k_q;
      end else begin
        c_q     <= c_q + ONE_A;
        b_off_q <= b_off_q + k_q;
      end
    end else begin
      t_q <= t_q + ONE_A;
    end
  end

  always_comb begin
    ena_o   = rd_en;
    enb_o   = rd_en;
    addra_o = '0;
    addrb_o = '0;
    if (rd_en) begin
      addra_o = base_a_q + ((a_off_q + t_q) << WORD_SHIFT);
      addrb_o = base_b_q + ((b_off_q + t_q) << WORD_SHIFT);
    end
  end

  // PE controls follow the read they belong to by one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pe_clr_q <= 1'b0;
      pe_we_q  <= 1'b0;
      bubble_q <= 1'b0;
      ensys_q  <= 1'b0;
    end else begin
      pe_clr_q <= !abort_i && rd_busy && (t_q == '0);
      pe_we_q  <= !abort_i && rd_busy && (t_q == k_q - ONE_A);
      bubble_q <= !abort_i && rd_busy && (t_q >= k_q);
      ensys_q  <= (main_d == M_RUN);
    end
  end

  assign pe_clr_o = pe_clr_q;
  assign pe_we_o  = pe_we_q;
  assign bubble_o = bubble_q;
  assign ensys_o  = ensys_q;

  // -------------------------------------------------------------------------
  // Write-back: pe_we delayed through the array and output pipeline, then one
  // burst per launch. Launches are at least TC >= ARRAY_DIM cycles apart, so
  // a new one can only land on or after the last word of the running burst.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else if (abort_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[SR_D-2:0], pe_we_q};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_active_q <= 1'b0;
      sel_q       <= '0;
      len_q       <= '0;
      wc_q        <= '0;
      wr_idx_q    <= '0;
    end else if (abort_i) begin
      wr_active_q <= 1'b0;
      sel_q       <= '0;
      len_q       <= '0;
      wc_q        <= '0;
      wr_idx_q    <= '0;
    end else begin
      if (run_go) begin
        wc_q     <= '0;
        wr_idx_q <= '0;
      end else if (wr_active_q) begin
        wr_idx_q <= wr_idx_q + ONE_A;
      end

      if (launch) begin
        // Column tiles arrive in c order; the last one may be narrower
        wr_active_q <= 1'b1;
        sel_q       <= '0;
        len_q       <= (wc_q == ct - ONE_A) ? last_w : DIM_L;
        wc_q        <= (wc_q == ct - ONE_A) ? '0 : wc_q + ONE_A;
      end else if (burst_end) begin
        wr_active_q <= 1'b0;
        sel_q       <= '0;
      end else if (wr_active_q) begin
        sel_q <= sel_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wr_q <= S_IDLE;
    else       wr_q <= wr_d;
  end

  always_comb begin
    wr_d = wr_q;
    unique case (wr_q)
      S_IDLE: if (run_go) wr_d = S_BUSY;
      S_BUSY: if (rd_q == S_DONE && sr_q == '0 && !pe_we_q && !wr_active_q)
                wr_d = S_DONE;
      S_DONE: if (main_q != M_RUN) wr_d = S_IDLE;
      default: wr_d = S_IDLE;
    endcase
    if (abort_i) wr_d = S_IDLE;
  end

  always_comb begin
    enp_o       = wr_active_q;
    wep_o       = wr_active_q;
    wordp_sel_o = sel_q;
    addrp_o     = '0;
    if (wr_active_q) addrp_o = base_p_q + (wr_idx_q << WORD_SHIFT);
  end

`ifdef MM_TILE_CTRL_PERF_EN
  // -------------------------------------------------------------------------
  // RUN-cycle counter: cleared on RUN entry, saturating, held afterwards
  // -------------------------------------------------------------------------
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt_q <= '0;
    end else if (abort_i || run_go) begin
      cycle_cnt_q <= '0;
    end else if (main_q == M_RUN && cycle_cnt_q != '1) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_mm_tile_controller.sv
// ---------------------------------------------------------------------------
// tb_mm_tile_controller
//
// Self-checking bench for mm_tile_controller. For each job a reference model
// expands the tiling rules into the full expected A/B read list and P write
// list, plus per-job pulse counts; the monitor pops these as the DUT issues
// accesses. Inputs are scrambled after start to confirm configuration is
// latched. Covers reset, directed jobs, zero-dimension rejection, abort,
// mid-job reset and randomized jobs.
// ---------------------------------------------------------------------------
module tb_mm_tile_controller;

  localparam int AW = 16;
  localparam int AD = 8;
  localparam int OL = 2;
  localparam int WS = 4;
  localparam int SW = $clog2(AD);
  localparam int BUDGET = 3000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i, abort_i;
  logic          valid_o, err_o;
  logic [AW-1:0] m_i, k_i, n_i, base_addra_i, base_addrb_i, base_addrp_i;
  logic          pe_clr_o, pe_we_o, ensys_o, bubble_o;
  logic          ena_o, enb_o, enp_o, wep_o;
  logic [AW-1:0] addra_o, addrb_o, addrp_o;
  logic [SW-1:0] wordp_sel_o;
`ifdef MM_TILE_CTRL_PERF_EN
  logic [31:0]   cycle_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mm_tile_controller #(
    .ADDR_WIDTH(AW), .ARRAY_DIM(AD), .OUTPUT_LAT(OL), .WORD_SHIFT(WS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .valid_o(valid_o), .err_o(err_o),
    .m_i(m_i), .k_i(k_i), .n_i(n_i),
    .base_addra_i(base_addra_i), .base_addrb_i(base_addrb_i),
    .base_addrp_i(base_addrp_i),
    .pe_clr_o(pe_clr_o), .pe_we_o(pe_we_o), .ensys_o(ensys_o),
    .bubble_o(bubble_o),
    .ena_o(ena_o), .addra_o(addra_o), .enb_o(enb_o), .addrb_o(addrb_o),
    .enp_o(enp_o), .wep_o(wep_o), .addrp_o(addrp_o),
    .wordp_sel_o(wordp_sel_o)
`ifdef MM_TILE_CTRL_PERF_EN
    , .cycle_cnt_o(cycle_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    m_i          = AW'($urandom);
    k_i          = AW'($urandom);
    n_i          = AW'($urandom);
    base_addra_i = AW'($urandom);
    base_addrb_i = AW'($urandom);
    base_addrp_i = AW'($urandom);
  endtask

  // One complete job: model, start, monitor until valid_o, release start.
  task automatic run_job(input int m, input int k, input int n,
                         input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                         input logic [AW-1:0] bp, input bit scramble);
    logic [AW-1:0] qa[$], qb[$], qp[$];
    int            qs[$];
    int            we_t[$];
    int rt, ct, tc, w, idx, cyc, n_we, n_clr, n_bub, n_run;
    bit exp_err, done;
    exp_err = (m == 0) || (k == 0) || (n == 0);
    rt = 0; ct = 0; tc = 0;
    if (!exp_err) begin
      rt  = (m + AD - 1) / AD;
      ct  = (n + AD - 1) / AD;
      tc  = (k > AD) ? k : AD;
      idx = 0;
      for (int r = 0; r < rt; r++)
        for (int c = 0; c < ct; c++) begin
          for (int t = 0; t < k; t++) begin
            qa.push_back(AW'(ba + ((r * k + t) << WS)));
            qb.push_back(AW'(bb + ((c * k + t) << WS)));
          end
          w = (c == ct - 1) ? n - (ct - 1) * AD : AD;
          for (int s = 0; s < w; s++) begin
            qp.push_back(AW'(bp + (idx << WS)));
            qs.push_back(s);
            idx++;
          end
        end
    end

    @(negedge clk_i);
    m_i = AW'(m); k_i = AW'(k); n_i = AW'(n);
    base_addra_i = ba; base_addrb_i = bb; base_addrp_i = bp;
    start_i = 1'b1;

    cyc = 0; done = 0; n_we = 0; n_clr = 0; n_bub = 0; n_run = 0;
    while (!done && cyc < BUDGET) begin
      @(negedge clk_i);
      cyc++;
      if (scramble) scramble_inputs();
      if (ensys_o) n_run++;
      if (ena_o) begin
        check("enb_with_ena", enb_o, 1'b1);
        if (qa.size() == 0) check("extra_read", 1'b1, 1'b0);
        else begin
          check("addra", addra_o, qa.pop_front());
          check("addrb", addrb_o, qb.pop_front());
        end
      end
      if (pe_we_o) begin
        n_we++;
        we_t.push_back(cyc);
      end
      if (pe_clr_o) n_clr++;
      if (bubble_o) n_bub++;
      if (enp_o) begin
        check("wep_with_enp", wep_o, 1'b1);
        if (wordp_sel_o == '0) begin
          if (we_t.size() == 0) check("burst_without_we", 1'b1, 1'b0);
          else check("we_to_burst_latency", cyc - we_t.pop_front(), AD + OL + 1);
        end
        if (qp.size() == 0) check("extra_write", 1'b1, 1'b0);
        else begin
          check("addrp", addrp_o, qp.pop_front());
          check("wordp_sel", wordp_sel_o, qs.pop_front());
        end
      end
      if (valid_o) done = 1;
    end

    check("job_completes", done, 1'b1);
    check("err_o", err_o, exp_err);
    check("reads_left", qa.size(), 0);
    check("writes_left", qp.size(), 0);
    check("pe_we_count", n_we, rt * ct);
    check("pe_clr_count", n_clr, rt * ct);
    check("bubble_count", n_bub, rt * ct * (tc - k));
    check("ensys_off_in_done", ensys_o, 1'b0);
    if (exp_err) check("zero_dim_latency", cyc, 1);
`ifdef MM_TILE_CTRL_PERF_EN
    check("cycle_cnt", cycle_cnt_o, n_run);
    @(negedge clk_i);
    check("cycle_cnt_hold", cycle_cnt_o, n_run);
`endif

    start_i = 1'b0;
    @(negedge clk_i);
    check("valid_released", valid_o, 1'b0);
    check("err_released", err_o, 1'b0);
  endtask

  // Start an 8x8x8 job and return once the first P write is visible
  task automatic start_and_wait_write();
    int cyc;
    @(negedge clk_i);
    m_i = 16'd8; k_i = 16'd8; n_i = 16'd8;
    base_addra_i = 16'h0100; base_addrb_i = 16'h0200; base_addrp_i = 16'h0300;
    start_i = 1'b1;
    cyc = 0;
    while (!enp_o && cyc < BUDGET) begin
      @(negedge clk_i);
      cyc++;
    end
    check("first_write_seen", enp_o, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    m_i = '0; k_i = '0; n_i = '0;
    base_addra_i = '0; base_addrb_i = '0; base_addrp_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_ctrl",
          {valid_o, err_o, pe_clr_o, pe_we_o, ensys_o, bubble_o, ena_o, enb_o,
           enp_o, wep_o}, 10'b0);
    check("reset_addr", {addra_o, addrb_o, addrp_o, wordp_sel_o}, '0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed jobs
    run_job(8, 8, 8, 16'h1000, 16'h2000, 16'h3000, 1'b0);
    run_job(10, 4, 12, 16'h0040, 16'h0800, 16'h4000, 1'b1);
    run_job(8, 0, 8, 16'h1000, 16'h2000, 16'h3000, 1'b0);
    run_job(0, 5, 3, 16'h1000, 16'h2000, 16'h3000, 1'b1);
    run_job(1, 1, 1, 16'hfff0, 16'h0000, 16'hfff8, 1'b1);

    // Abort mid-burst with start still high: abort must win
    start_and_wait_write();
    repeat (2) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    check("abort_enp", enp_o, 1'b0);
    check("abort_ena", ena_o, 1'b0);
    check("abort_ctrl", {valid_o, err_o, pe_clr_o, pe_we_o, ensys_o, bubble_o},
          6'b0);
    check("abort_addrp", addrp_o, '0);
    abort_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    check("abort_no_valid", valid_o, 1'b0);
    run_job(8, 8, 8, 16'h0010, 16'h0020, 16'h0500, 1'b0);

    // Asynchronous reset in the middle of a job
    start_and_wait_write();
    rst_i = 1'b1;
    #1;
    check("midreset_ctrl", {valid_o, enp_o, ena_o, ensys_o, pe_we_o}, 5'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    check("midreset_no_valid", valid_o, 1'b0);

    // Randomized jobs with inputs scrambled after start
    for (int j = 0; j < 12; j++)
      run_job($urandom_range(1, 20), $urandom_range(1, 12),
              $urandom_range(1, 20), AW'($urandom), AW'($urandom),
              AW'($urandom), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
